// File: rtl/probe_scan_reader.sv
// probe_scan_reader: drives the target's display select, optionally issues one
// single-step clock pulse first, captures one probe byte per select value and
// offers the assembled snapshot through a valid/ready handshake.
module probe_scan_reader #(
    parameter int NSEL      = 5,
    parameter int SEL_W     = 3,
    parameter int DW        = 8,
    parameter int SETTLE    = 2,
    parameter int STEP_HIGH = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic                 Step,
    output logic                 StepClk,
    output logic [SEL_W-1:0]     Sel,
    input  logic [DW-1:0]        Probe,
    output logic [NSEL*DW-1:0]   Snap,
    output logic                 Valid,
    input  logic                 Ready,
    output logic                 Busy
);

    localparam int IW = $clog2(NSEL) + 1;

    // Terminal counts; cnt is shared by the step pulse phases and the settle window.
    localparam logic [3:0]    STEP_LAST   = 4'(STEP_HIGH - 1);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NSEL - 1);

    typedef enum logic [2:0] {
        IDLE,
        STEP_HI,
        STEP_LO,
        SCAN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NSEL*DW-1:0]    snap_q, snap_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  stepclk_q, stepclk_d;

    // Next-state and next-output computation for the scan sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        snap_d    = snap_q;
        valid_d   = valid_q;
        stepclk_d = stepclk_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    cnt_d = 4'd0;
                    if (Step) begin
                        state_d   = STEP_HI;
                        stepclk_d = 1'b1;
                    end else begin
                        state_d = SCAN;
                        sel_d   = '0;
                        idx_d   = '0;
                    end
                end
            end

            STEP_HI: begin
                if (cnt_q == STEP_LAST) begin
                    state_d   = STEP_LO;
                    stepclk_d = 1'b0;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            STEP_LO: begin
                if (cnt_q == STEP_LAST) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    idx_d   = '0;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    // Last cycle of the settle window: Probe reflects the current Sel.
                    for (int i = 0; i < NSEL; i++) begin
                        if (idx_q == IW'(i)) begin
                            snap_d[i*DW +: DW] = Probe;
                        end
                    end
                    cnt_d = 4'd0;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        sel_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        sel_d = SEL_W'(idx_q + 1'b1);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: begin
                if (Ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any pulse or scan immediately.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            sel_q     <= '0;
            snap_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            stepclk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            snap_q    <= snap_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            stepclk_q <= stepclk_d;
        end
    end

    assign StepClk = stepclk_q;
    assign Sel     = sel_q;
    assign Snap    = snap_q;
    assign Valid   = valid_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_probe_scan_reader.sv
// Directed testbench for probe_scan_reader with a behavioural target model.
module tb_probe_scan_reader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        Step = 1'b0;
    logic        StepClk;
    logic [2:0]  Sel;
    logic [7:0]  Probe;
    logic [39:0] Snap;
    logic        Valid;
    logic        Ready = 1'b0;
    logic        Busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Target model: mode 0 = fixed pattern, 1 = step counter + Sel, 2 = noise.
    logic [1:0] mode = 2'd0;
    logic [7:0] stepcnt;
    logic       cnt_clr = 1'b0;
    logic [7:0] noise = 8'h00;

    always @(posedge StepClk or posedge cnt_clr) begin
        if (cnt_clr) stepcnt <= 8'd0;
        else         stepcnt <= stepcnt + 8'd1;
    end

    assign Probe = (mode == 2'd0) ? 8'({1'b0, Sel, 4'hA}) :
                   (mode == 2'd1) ? 8'(stepcnt + {5'd0, Sel}) : noise;

    probe_scan_reader dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .Step    (Step),
        .StepClk (StepClk),
        .Sel     (Sel),
        .Probe   (Probe),
        .Snap    (Snap),
        .Valid   (Valid),
        .Ready   (Ready),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [39:0] exp_snap);
        check_eq({tag, "_stepclk"}, 64'(StepClk), 64'd0);
        check_eq({tag, "_sel"},     64'(Sel),     64'd0);
        check_eq({tag, "_valid"},   64'(Valid),   64'd0);
        check_eq({tag, "_busy"},    64'(Busy),    64'd0);
        check_eq({tag, "_snap"},    64'(Snap),    64'(exp_snap));
    endtask

    // Issues Start, follows Sel/StepClk cycle by cycle until Valid, then checks
    // latency and snapshot. Without hold, Start is pulsed again mid-scan.
    task automatic run_scan(input string tag, input bit step, input int lat,
                            input logic [39:0] exp_snap, input bit hold);
        int c;
        int off;
        logic exp_clk;
        logic [2:0] exp_sel;
        off = step ? 4 : 0;
        Start = 1'b1;
        Step  = step;
        tick();
        if (!hold) Start = 1'b0;
        Step = 1'b0;
        c = 0;
        while (Valid !== 1'b1 && c < 60) begin
            exp_clk = step && (c < 2);
            exp_sel = (c < off) ? 3'd0 : 3'((c - off) / 3);
            check_eq({tag, "_stepclk"}, 64'(StepClk), 64'(exp_clk));
            check_eq({tag, "_sel"},     64'(Sel),     64'(exp_sel));
            check_eq({tag, "_busy"},    64'(Busy),    64'd1);
            if (!hold && c == 5) Start = 1'b1;
            if (!hold && c == 7) Start = 1'b0;
            tick();
            c++;
        end
        check_eq({tag, "_latency"}, 64'(c), 64'(lat));
        check_eq({tag, "_snap"},    64'(Snap), 64'(exp_snap));
        check_eq({tag, "_sel_done"}, 64'(Sel), 64'd0);
        check_eq({tag, "_stepclk_done"}, 64'(StepClk), 64'd0);
    endtask

    initial begin
        int c;
        cnt_clr = 1'b1;
        tick();
        check_idle_outputs("reset", 40'h0);
        Rst = 1'b0;
        cnt_clr = 1'b0;
        tick();
        check_idle_outputs("reset_idle", 40'h0);

        // Basic scan, Ready already high.
        mode = 2'd0;
        Ready = 1'b1;
        run_scan("basic", 1'b0, 15, 40'h4A3A2A1A0A, 1'b0);
        tick();
        check_idle_outputs("basic_end", 40'h4A3A2A1A0A);

        // One step pulse before the scan.
        cnt_clr = 1'b1;
        #1 cnt_clr = 1'b0;
        mode = 2'd1;
        run_scan("step", 1'b1, 19, 40'h0504030201, 1'b0);
        tick();
        check_idle_outputs("step_end", 40'h0504030201);

        // Backpressure: hold Ready low while the probe bus churns.
        mode = 2'd0;
        Ready = 1'b0;
        run_scan("bp", 1'b0, 15, 40'h4A3A2A1A0A, 1'b0);
        mode = 2'd2;
        for (int i = 0; i < 10; i++) begin
            noise = 8'($urandom);
            tick();
            check_eq("bp_valid_hold", 64'(Valid), 64'd1);
            check_eq("bp_snap_hold",  64'(Snap),  64'h4A3A2A1A0A);
        end
        Ready = 1'b1;
        tick();
        check_idle_outputs("bp_end", 40'h4A3A2A1A0A);

        // Back-to-back: Start held through completion.
        mode = 2'd1;
        cnt_clr = 1'b1;
        #1 cnt_clr = 1'b0;
        run_scan("b2b", 1'b0, 15, 40'h0403020100, 1'b1);
        tick();
        check_eq("b2b_valid_clr", 64'(Valid), 64'd0);
        check_eq("b2b_idle",      64'(Busy),  64'd0);
        tick();
        check_eq("b2b_restart",   64'(Busy),  64'd1);
        check_eq("b2b_sel0",      64'(Sel),   64'd0);
        Start = 1'b0;
        mode = 2'd0;
        c = 0;
        while (Valid !== 1'b1 && c < 60) begin
            tick();
            c++;
        end
        check_eq("b2b_latency2", 64'(c), 64'd15);
        check_eq("b2b_snap2",    64'(Snap), 64'h4A3A2A1A0A);
        tick();
        check_idle_outputs("b2b_end", 40'h4A3A2A1A0A);

        // Reset during STEP_HI.
        Start = 1'b1;
        Step = 1'b1;
        tick();
        Start = 1'b0;
        Step = 1'b0;
        tick();
        check_eq("rst_hi_pre_stepclk", 64'(StepClk), 64'd1);
        #2 Rst = 1'b1;
        #1;
        check_idle_outputs("rst_hi", 40'h0);
        #1 Rst = 1'b0;
        tick();
        check_idle_outputs("rst_hi_after", 40'h0);

        // Reset in SCAN at Sel=2.
        run_scan("pre", 1'b0, 15, 40'h4A3A2A1A0A, 1'b0);
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (6) tick();
        check_eq("rst_scan_pre_sel", 64'(Sel), 64'd2);
        #2 Rst = 1'b1;
        #1;
        check_idle_outputs("rst_scan", 40'h0);
        #1 Rst = 1'b0;
        tick();
        run_scan("post_rst", 1'b0, 15, 40'h4A3A2A1A0A, 1'b0);
        tick();
        check_idle_outputs("post_rst_end", 40'h4A3A2A1A0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
